// File: rtl/gametank_joypad_port_pkg.sv
// gametank_joypad_port_pkg: button layout, vector widths and serial byte composition for the joypad port
package gametank_joypad_port_pkg;
  localparam int JOY_W = 12;
  localparam int JOY_SER_W = 8;
  localparam int BTN_B = 0;
  localparam int BTN_Y = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LT = 6;
  localparam int BTN_RT = 7;
  localparam int BTN_A = 8;
  localparam int BTN_X = 9;
  localparam int BTN_L = 10;
  localparam int BTN_R = 11;
  typedef logic [JOY_W-1:0] joy_t;
  typedef logic [JOY_SER_W-1:0] ser_t;
  function automatic ser_t compose(ser_t low, logic af_a, logic af_x);
    return {low[JOY_SER_W-1:2], low[BTN_Y] | af_x, low[BTN_B] | af_a};
  endfunction
endpackage

// File: rtl/gametank_joypad_port_if.sv
// gametank_joypad_port_if: core-side joypad pins; master is the core, slave is the joypad port
interface gametank_joypad_port_if;
  logic       joypad_strobe;
  logic [1:0] joypad_clock;
  logic [4:0] joypad1_data;
  logic [4:0] joypad2_data;
  modport master(output joypad_strobe, joypad_clock, input joypad1_data, joypad2_data);
  modport slave(input joypad_strobe, joypad_clock, output joypad1_data, joypad2_data);
endinterface

// File: rtl/gametank_joypad_port_turbo.sv
// gametank_turbo: one autofire channel, fires immediately on press then toggles every AF_HALF cycles
module gametank_turbo #(
  parameter int AF_HALF = 357950
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic out
);
  localparam int CW = AF_HALF > 1 ? $clog2(AF_HALF) : 1;
  logic [CW-1:0] cnt;
  logic          btn_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= 1'b0;
      cnt   <= '0;
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
      if (!btn) begin
        out <= 1'b0;
        cnt <= '0;
      end else if (!btn_q) begin
        out <= 1'b1;
        cnt <= '0;
      end else if (cnt == CW'(AF_HALF - 1)) begin
        out <= ~out;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gametank_joypad_port.sv
// gametank_joypad_port: latches/shifts two NES-style serial joypads with turbo, port swap and home combo
module gametank_joypad_port
  import gametank_joypad_port_pkg::*;
#(
  parameter int AF_HALF   = 357950,
  parameter int HOME_HOLD = 2147700
) (
  input  logic                         clk,
  input  logic                         reset,
  input  joy_t                         joy1,
  input  joy_t                         joy2,
  input  logic                         joy_swap,
  input  logic                         turbo_en,
  gametank_joypad_port_if.slave        jp,
  output logic                         home_req
);
  localparam int HW = $clog2(HOME_HOLD + 1);
  joy_t          src1, src2;
  logic [3:0]    af_btn, af, af_g;
  ser_t          byte1, byte2, sr1, sr2;
  logic [1:0]    last_clk, falls;
  logic [HW-1:0] hold;
  logic          combo;
  logic          unused_ok;
  assign src1   = joy_swap ? joy2 : joy1;
  assign src2   = joy_swap ? joy1 : joy2;
  assign af_btn = {src2[BTN_X], src2[BTN_A], src1[BTN_X], src1[BTN_A]};
  for (genvar i = 0; i < 4; i++) begin : g_af
    gametank_turbo #(.AF_HALF(AF_HALF)) u_af (
      .clk  (clk),
      .reset(reset),
      .btn  (af_btn[i]),
      .out  (af[i])
    );
  end
  assign af_g      = af & {4{turbo_en}};
  assign byte1     = compose(src1[JOY_SER_W-1:0], af_g[0], af_g[1]);
  assign byte2     = compose(src2[JOY_SER_W-1:0], af_g[2], af_g[3]);
  assign falls     = last_clk & ~jp.joypad_clock;
  assign combo     = joy1[BTN_SELECT] & joy1[BTN_DOWN];
  assign unused_ok = ^{src1[BTN_R:BTN_L], src2[BTN_R:BTN_L]};
  // Reload wins over a coincident falling edge; shifting backfills ones like a real 4021.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr1      <= '0;
      sr2      <= '0;
      last_clk <= '0;
      hold     <= '0;
      home_req <= 1'b0;
    end else begin
      last_clk <= jp.joypad_clock;
      sr1      <= jp.joypad_strobe ? byte1 : falls[0] ? {1'b1, sr1[JOY_SER_W-1:1]} : sr1;
      sr2      <= jp.joypad_strobe ? byte2 : falls[1] ? {1'b1, sr2[JOY_SER_W-1:1]} : sr2;
      hold     <= !combo ? '0 : hold == HW'(HOME_HOLD) ? hold : hold + 1'b1;
      home_req <= combo && hold == HW'(HOME_HOLD - 1);
    end
  end
  assign jp.joypad1_data = {4'b0, sr1[0]};
  assign jp.joypad2_data = {4'b0, sr2[0]};
endmodule

// File: tb/tb_gametank_joypad_port.sv
// tb_gametank_joypad_port: directed vectors checked against a behavioural model every cycle plus literal pins
module tb_gametank_joypad_port;
  localparam int AF = 4;
  localparam int HH = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] joy1 = '0;
  logic [11:0] joy2 = '0;
  logic        joy_swap = 1'b0;
  logic        turbo_en = 1'b0;
  logic        home_req;
  int          checks = 0;
  int          errors = 0;
  gametank_joypad_port_if jp();
  gametank_joypad_port #(.AF_HALF(AF), .HOME_HOLD(HH)) dut (
    .clk     (clk),
    .reset   (reset),
    .joy1    (joy1),
    .joy2    (joy2),
    .joy_swap(joy_swap),
    .turbo_en(turbo_en),
    .jp      (jp),
    .home_req(home_req)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each port remembers the byte latched and how many bits were read since;
  // turbo is press age in cycles, home is length of the continuous combo hold.
  logic [7:0] m_byte[2];
  int         m_cnt[2];
  logic [1:0] m_last;
  logic       m_held[4];
  int         m_age[4];
  logic [3:0] m_af;
  int         m_hold;
  logic       m_home;
  always @(posedge clk) begin
    logic [11:0] s[2];
    logic [3:0]  btns;
    logic [7:0]  b;
    s[0] = joy_swap ? joy2 : joy1;
    s[1] = joy_swap ? joy1 : joy2;
    btns = {s[1][9], s[1][8], s[0][9], s[0][8]};
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_byte[p] = '0;
        m_cnt[p]  = 0;
      end
      for (int c = 0; c < 4; c++) begin
        m_held[c] = 1'b0;
        m_age[c]  = 0;
      end
      m_last = '0;
      m_af   = '0;
      m_hold = 0;
      m_home = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        b = s[p][7:0];
        if (turbo_en) b[1:0] = b[1:0] | {m_af[2*p+1], m_af[2*p]};
        if (jp.joypad_strobe) begin
          m_byte[p] = b;
          m_cnt[p]  = 0;
        end else if (m_last[p] && !jp.joypad_clock[p] && m_cnt[p] < 8) begin
          m_cnt[p]++;
        end
      end
      m_last = jp.joypad_clock;
      for (int c = 0; c < 4; c++) begin
        if (!btns[c]) begin
          m_held[c] = 1'b0;
          m_age[c]  = 0;
        end else if (!m_held[c]) begin
          m_held[c] = 1'b1;
          m_age[c]  = 0;
        end else begin
          m_age[c]++;
        end
        m_af[c] = btns[c] && ((m_age[c] / AF) % 2 == 0);
      end
      m_hold = (joy1[2] && joy1[5]) ? m_hold + 1 : 0;
      m_home = (m_hold == HH);
    end
    #1;
    chk("model_data1", jp.joypad1_data, {4'b0, m_cnt[0] < 8 ? m_byte[0][m_cnt[0]] : 1'b1});
    chk("model_data2", jp.joypad2_data, {4'b0, m_cnt[1] < 8 ? m_byte[1][m_cnt[1]] : 1'b1});
    chk("model_home", home_req, m_home);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fall(input logic [1:0] m);
    jp.joypad_clock = m;
    tick();
    jp.joypad_clock = 2'b00;
    tick();
  endtask

  task automatic strobe_once();
    jp.joypad_strobe = 1'b1;
    tick();
    jp.joypad_strobe = 1'b0;
    tick();
  endtask

  initial begin
    logic [9:0] seq_a, seq_b, seq_c;
    seq_a = 10'b1100001001;
    seq_b = 10'b1100010000;
    seq_c = 10'b1100000000;
    jp.joypad_strobe = 1'b0;
    jp.joypad_clock  = 2'b00;
    repeat (3) tick();
    chk("rst_data1", jp.joypad1_data, 5'h00);
    chk("rst_data2", jp.joypad2_data, 5'h00);
    chk("rst_home", home_req, 1'b0);
    reset = 1'b0;
    tick();
    joy1 = 12'h009;
    strobe_once();
    chk("t1_bit0", jp.joypad1_data, {4'b0, seq_a[0]});
    for (int i = 1; i < 10; i++) begin
      fall(2'b01);
      chk("t1_seq", jp.joypad1_data, {4'b0, seq_a[i]});
    end
    joy1     = 12'h000;
    joy2     = 12'h010;
    joy_swap = 1'b1;
    strobe_once();
    chk("t2_p1_bit0", jp.joypad1_data[0], seq_b[0]);
    chk("t2_p2_bit0", jp.joypad2_data[0], seq_c[0]);
    for (int i = 1; i < 10; i++) begin
      fall(2'b11);
      chk("t2_p1_seq", jp.joypad1_data[0], seq_b[i]);
      chk("t2_p2_seq", jp.joypad2_data[0], seq_c[i]);
    end
    joy_swap = 1'b0;
    joy2     = 12'h000;
    joy1     = 12'h001;
    jp.joypad_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fall(2'b01);
      chk("t3_no_shift", jp.joypad1_data[0], 1'b1);
    end
    jp.joypad_strobe = 1'b0;
    tick();
    joy1     = 12'h100;
    turbo_en = 1'b1;
    jp.joypad_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t4_turbo", jp.joypad1_data[0], i == 0 ? 1'b0 : (((i - 1) / 4) % 2 == 0));
    end
    turbo_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_turbo_off", jp.joypad1_data[0], 1'b0);
    end
    jp.joypad_strobe = 1'b0;
    joy1 = 12'h000;
    tick();
    joy1 = 12'h024;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5_first", home_req, c == 10);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("t5_held", home_req, 1'b0);
    end
    joy1 = 12'h000;
    tick();
    joy1 = 12'h024;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5_second", home_req, c == 10);
    end
    joy1 = 12'h000;
    tick();
    joy1 = 12'h024;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t5_short", home_req, 1'b0);
    end
    joy1 = 12'h000;
    tick();
    chk("t5_short_rel", home_req, 1'b0);
    joy1 = 12'h0F7;
    strobe_once();
    for (int i = 0; i < 3; i++) fall(2'b01);
    chk("t6_pre", jp.joypad1_data[0], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_data", jp.joypad1_data, 5'h00);
    joy1 = 12'h000;
    fall(2'b01);
    chk("t6_zero_sr", jp.joypad1_data[0], 1'b0);
    joy1 = 12'h0A5;
    strobe_once();
    chk("t6_reload0", jp.joypad1_data[0], 1'b1);
    fall(2'b01);
    chk("t6_reload1", jp.joypad1_data[0], 1'b0);
    fall(2'b01);
    chk("t6_reload2", jp.joypad1_data[0], 1'b1);
    joy1 = 12'h024;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_hold_rst", home_req, 1'b0);
    end
    joy1 = 12'h000;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
